inst_fetch: RTL
===============

# inst_fetch

Instruction fetch unit that drives the instruction memory as its only requester. It holds the program counter and presents a byte address to the memory each cycle. It registers the returned 16-bit word, together with its PC, toward the decode stage. It supports stall, branch redirect, halt-word detection and fetch-fault detection, and sits between the instruction memory and decode in the CPU datapath.

## Interface
- ADDR_WIDTH, 16, byte address width of imem_addr / PC
- DATA_WIDTH, 16, instruction word width
- RESET_PC, 16'h0000, PC loaded on reset
- MEM_BYTES, 52, size of instruction memory in bytes (26 words); PC >= MEM_BYTES is out of range
- HALT_WORD, 16'hEFFF, instruction word that ends the program

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory; combinationally equal to PC register
- imem_data  input  DATA_WIDTH  word returned combinationally for imem_addr
- imem_exc  input  1  memory exception for current address
- stall  input  1  decode cannot accept; hold current output
- redirect  input  1  branch taken; load redirect_pc
- redirect_pc  input  ADDR_WIDTH  branch target byte address
- inst  output  DATA_WIDTH  fetched instruction
- inst_pc  output  ADDR_WIDTH  byte address of inst
- inst_valid  output  1  inst/inst_pc valid
- halted  output  1  HALT_WORD fetched; fetch stopped
- fault  output  1  fetch fault; fetch stopped

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset (rst==0 at a clock edge) sets all registers regardless of state:
  - state=BOOT, PC=RESET_PC, inst=0, inst_pc=0.
  - inst_valid=0, halted=0, fault=0.
  - imem_addr reads RESET_PC.
- BOOT: one cycle, giving memory contents time to settle after reset release. Outputs unchanged. Next state is RUN. redirect is ignored.
- RUN, per edge, in priority order:
  1. redirect=1: PC<=redirect_pc, inst_valid<=0 (flush). Redirect beats stall.
  2. stall=1 and inst_valid=1: hold PC, inst, inst_pc and inst_valid. stall with inst_valid=0 does not block fetch.
  3. Fault check: pc[0]=1, PC>=MEM_BYTES, or imem_exc=1 → state<=FAULT, fault<=1, inst_valid<=0, PC held.
  4. Otherwise issue: inst<=imem_data, inst_pc<=PC, inst_valid<=1.
     - If imem_data==HALT_WORD: state<=HALT, halted<=1, PC held at the halt address.
     - Else PC<=PC+2, modulo 2^ADDR_WIDTH. Wrap is then caught by the range check.
- HALT:
  - The halt word stays valid until accepted. On the first edge with stall=0, inst_valid<=0.
  - redirect and stall are otherwise ignored. Exit only by reset.
- FAULT:
  - inst_valid=0, fault=1, imem_addr holds the faulting PC.
  - Inputs are ignored. Exit only by reset.
- halted and fault are never both 1.

## Timing
- Fetch latency: an address presented in cycle N is registered at the end of N, so inst_valid=1 in N+1.
- Throughput: one instruction per cycle when stall=0.
- After reset release:
  - Edge 1: BOOT→RUN.
  - Edge 2: first instruction registered; inst_valid=1 after the 2nd rising edge with rst=1.
- Redirect:
  - Asserted in cycle N: inst_valid=0 in N+1, with imem_addr=redirect_pc.
  - Target instruction valid in N+2.
  - The instruction present in cycle N is dropped if a redirect and a stall coincide.
- Stall: outputs are bit-stable for every cycle stall=1 with inst_valid=1. Issue resumes on the first edge with stall=0.
- Reset mid-operation: takes effect on the next edge irrespective of state, stall or redirect. Any in-flight instruction is discarded.

## Test plan
- Straight-line fetch, memory preloaded with the standard program:
  - Release rst, stall=0.
  - Required: inst_valid first rises after edge 2, with inst=16'h012F, inst_pc=0.
  - Next cycle inst=16'h012E, inst_pc=2. Then 16'h034C, inst_pc=4.
- Stall hold:
  - Assert stall for 3 cycles while inst_pc=6 (16'h032D).
  - Required: inst, inst_pc and imem_addr=8 are constant throughout.
  - After release, inst=16'h0561, inst_pc=8 next cycle.
- Redirect:
  - Pulse redirect with redirect_pc=16'h001E in the cycle inst_pc=16'h16.
  - Required: next cycle inst_valid=0, imem_addr=16'h1E.
  - Following cycle inst=16'h5702, inst_pc=16'h1E. Redirect+stall together still redirects.
- Halt:
  - Run to 16'h32.
  - Required: inst=16'hEFFF, inst_pc=16'h32, halted=1, imem_addr stays 16'h32.
  - inst_valid drops on the first stall=0 edge.
  - Later redirect pulses have no effect.
- Faults:
  - redirect_pc=16'h0005 → fault=1 two cycles later (one cycle after imem_addr=5), inst_valid=0.
  - After reset, redirect_pc=16'h0040 → fault=1.
  - After reset, force imem_exc=1 at PC 4 → fault=1, imem_addr=4.
- Reset mid-run:
  - Assert rst=0 for one edge while PC=16'h14 and stall=1.
  - Required: next cycle PC=0, inst_valid=0, halted=0, fault=0.
  - Then the normal boot sequence.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the instruction memory and
// registers each fetched word with its address toward decode.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter int                    MEM_BYTES  = 52,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 16'hEFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  imem_exc,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [DATA_WIDTH-1:0] r_inst, w_inst_next;
  logic [ADDR_WIDTH-1:0] r_inst_pc, w_inst_pc_next;
  logic                  r_valid, w_valid_next;
  logic                  r_halted, w_halted_next;
  logic                  r_fault, w_fault_next;
  logic                  w_bad_fetch;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_inst    <= w_inst_next;
      r_inst_pc <= w_inst_pc_next;
      r_valid   <= w_valid_next;
      r_halted  <= w_halted_next;
      r_fault   <= w_fault_next;
    end
  end

  assign w_bad_fetch = r_pc[0] | (r_pc >= MEM_LIMIT) | imem_exc;

  // Redirect outranks stall; a stall only blocks once there is something to hold.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_inst_next    = r_inst;
    w_inst_pc_next = r_inst_pc;
    w_valid_next   = r_valid;
    w_halted_next  = r_halted;
    w_fault_next   = r_fault;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        if (redirect) begin
          w_pc_next    = redirect_pc;
          w_valid_next = 1'b0;
        end else if (stall && r_valid) begin
          w_pc_next = r_pc;
        end else if (w_bad_fetch) begin
          w_state_next = FAULT;
          w_fault_next = 1'b1;
          w_valid_next = 1'b0;
        end else begin
          w_inst_next    = imem_data;
          w_inst_pc_next = r_pc;
          w_valid_next   = 1'b1;
          if (imem_data == HALT_WORD) begin
            w_state_next  = HALT;
            w_halted_next = 1'b1;
          end else begin
            w_pc_next = r_pc + ADDR_WIDTH'(2);
          end
        end
      end
      HALT: begin
        if (!stall) w_valid_next = 1'b0;
      end
      FAULT: w_valid_next = 1'b0;
      default: w_state_next = BOOT;
    endcase
  end

  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;
  assign halted     = r_halted;
  assign fault      = r_fault;

endmodule
